// File: rtl/code_lock_pkg.sv
// code_lock_pkg: shared definitions for the three-button combination lock.
//   state_t        : FSM state encodings (3-bit, IDLE=0 .. LOCKOUT=4)
//   SYM0..SYM2     : symbols produced by the X0/X1/X2 press pulses
//   SYM_INVALID    : simultaneous presses; never matches any code symbol
//   decode_symbol  : maps the {X2,X1,X0} press vector to a symbol
package code_lock_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ENTRY   = 3'd1,
        ST_CHECK   = 3'd2,
        ST_OPEN    = 3'd3,
        ST_LOCKOUT = 3'd4
    } state_t;

    localparam logic [1:0] SYM0        = 2'd0;
    localparam logic [1:0] SYM1        = 2'd1;
    localparam logic [1:0] SYM2        = 2'd2;
    localparam logic [1:0] SYM_INVALID = 2'd3;

    // Exactly one press line gives its symbol; anything else is invalid.
    function automatic logic [1:0] decode_symbol(input logic [2:0] presses);
        case (presses)
            3'b001:  return SYM0;
            3'b010:  return SYM1;
            3'b100:  return SYM2;
            default: return SYM_INVALID;
        endcase
    endfunction

endpackage

// File: rtl/code_lock_hold_timer.sv
// hold_timer: loadable down-counter shared by the OPEN and LOCKOUT dwell times.
//   clk, rst_n  : clock, asynchronous active-low reset
//   load        : load load_value this cycle (overrides counting)
//   load_value  : value loaded on load
//   done        : registered, high while the count equals 1 (last dwell cycle)
module hold_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_value,
    output logic         done
);

    logic [W-1:0] count;
    logic [W-1:0] count_next;

    // Count down to zero and rest there until reloaded.
    always_comb begin
        count_next = count;
        if (load) begin
            count_next = load_value;
        end else if (count != '0) begin
            count_next = count - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            done  <= 1'b0;
        end else begin
            count <= count_next;
            done  <= (count_next == W'(1));
        end
    end

endmodule

// File: rtl/code_lock.sv
// code_lock: three-button combination lock fed by debounced press pulses.
//   sysclk          : clock
//   reset           : asynchronous active-low reset
//   X0/X1/X2_deb    : single-cycle press pulses for symbols 0/1/2
//   code            : expected sequence, symbol i at code[2i+1:2i], i=0 first
//   unlocked        : high while the lock is open
//   error           : one-cycle pulse on a failed entry
//   locked_out      : high during lockout (tied 0 unless CODE_LOCK_LOCKOUT_EN)
//   digit_count     : presses taken in the current entry
// Optional feature: define CODE_LOCK_LOCKOUT_EN for the fail counter and lockout.
module code_lock
    import code_lock_pkg::*;
#(
    parameter int unsigned CODE_LEN       = 4,
    parameter int unsigned UNLOCK_CYCLES  = 50_000_000,
    parameter int unsigned LOCKOUT_CYCLES = 250_000_000,
    parameter int unsigned MAX_FAILS      = 3
) (
    input  logic                          sysclk,
    input  logic                          reset,
    input  logic                          X0_deb,
    input  logic                          X1_deb,
    input  logic                          X2_deb,
    input  logic [2*CODE_LEN-1:0]         code,
    output logic                          unlocked,
    output logic                          error,
    output logic                          locked_out,
    output logic [$clog2(CODE_LEN+1)-1:0] digit_count
);

    localparam int unsigned DC_W      = $clog2(CODE_LEN + 1);
    localparam int unsigned TIMER_MAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES
                                                                         : LOCKOUT_CYCLES;
    localparam int unsigned TIMER_W   = $clog2(TIMER_MAX + 1);

    // Reject nonsensical parameter sets at elaboration.
    if (CODE_LEN < 1 || CODE_LEN > 8 || UNLOCK_CYCLES < 1 ||
        LOCKOUT_CYCLES < 1 || MAX_FAILS < 1) begin : g_bad_params
        $error("code_lock: parameter out of range");
    end

    state_t             state, state_next;
    logic [DC_W-1:0]    digit_count_next;
    logic               match, match_next;
    logic               error_next;
    logic [2:0]         presses;
    logic               press;
    logic [1:0]         sym, code_sym;
    logic               sym_ok;
    logic               timer_load;
    logic [TIMER_W-1:0] timer_value;
    logic               timer_done;

`ifdef CODE_LOCK_LOCKOUT_EN
    localparam int unsigned FAIL_W = $clog2(MAX_FAILS + 1);
    logic [FAIL_W-1:0] fail_cnt, fail_next;
`endif

    assign presses = {X2_deb, X1_deb, X0_deb};
    assign press   = |presses;
    assign sym     = decode_symbol(presses);
    assign sym_ok  = (sym != SYM_INVALID) && (sym == code_sym);

    // Code symbol expected at the current position.
    always_comb begin
        code_sym = SYM_INVALID;
        for (int unsigned i = 0; i < CODE_LEN; i++) begin
            if (digit_count == DC_W'(i)) begin
                code_sym = code[2*i +: 2];
            end
        end
    end

    hold_timer #(.W(TIMER_W)) u_hold_timer (
        .clk        (sysclk),
        .rst_n      (reset),
        .load       (timer_load),
        .load_value (timer_value),
        .done       (timer_done)
    );

    // Next-state and datapath control.
    always_comb begin
        state_next       = state;
        digit_count_next = digit_count;
        match_next       = match;
        error_next       = 1'b0;
        timer_load       = 1'b0;
        timer_value      = '0;
`ifdef CODE_LOCK_LOCKOUT_EN
        fail_next        = fail_cnt;
`endif
        case (state)
            ST_IDLE, ST_ENTRY: begin
                if (press) begin
                    match_next       = match & sym_ok;
                    digit_count_next = digit_count + DC_W'(1);
                    state_next       = (digit_count == DC_W'(CODE_LEN - 1)) ? ST_CHECK : ST_ENTRY;
                end
            end
            ST_CHECK: begin
                digit_count_next = '0;
                match_next       = 1'b1;
                if (match) begin
                    state_next  = ST_OPEN;
                    timer_load  = 1'b1;
                    timer_value = TIMER_W'(UNLOCK_CYCLES);
`ifdef CODE_LOCK_LOCKOUT_EN
                    fail_next   = '0;
`endif
                end else begin
                    error_next = 1'b1;
                    state_next = ST_IDLE;
`ifdef CODE_LOCK_LOCKOUT_EN
                    fail_next  = fail_cnt + FAIL_W'(1);
                    if (fail_cnt == FAIL_W'(MAX_FAILS - 1)) begin
                        state_next  = ST_LOCKOUT;
                        timer_load  = 1'b1;
                        timer_value = TIMER_W'(LOCKOUT_CYCLES);
                    end
`endif
                end
            end
            ST_OPEN: begin
                if (timer_done) begin
                    state_next = ST_IDLE;
                end
            end
`ifdef CODE_LOCK_LOCKOUT_EN
            ST_LOCKOUT: begin
                if (timer_done) begin
                    state_next = ST_IDLE;
                    fail_next  = '0;
                end
            end
`endif
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            digit_count <= '0;
            match       <= 1'b1;
            unlocked    <= 1'b0;
            error       <= 1'b0;
        end else begin
            state       <= state_next;
            digit_count <= digit_count_next;
            match       <= match_next;
            unlocked    <= (state_next == ST_OPEN);
            error       <= error_next;
        end
    end

`ifdef CODE_LOCK_LOCKOUT_EN
    // Failure counter and lockout indicator.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            fail_cnt   <= '0;
            locked_out <= 1'b0;
        end else begin
            fail_cnt   <= fail_next;
            locked_out <= (state_next == ST_LOCKOUT);
        end
    end
`else
    assign locked_out = 1'b0;
`endif

endmodule

// File: tb/tb_code_lock.sv
// tb_code_lock: directed + randomized bench for code_lock against a
// sequence-level reference model (entered symbol list, dwell countdowns).
module tb_code_lock;

    localparam int CL = 4;
    localparam int UC = 8;
    localparam int LC = 16;
    localparam int MF = 3;
`ifdef CODE_LOCK_LOCKOUT_EN
    localparam bit LOCKOUT_EN = 1'b1;
`else
    localparam bit LOCKOUT_EN = 1'b0;
`endif

    localparam logic [2:0] P0 = 3'b001;
    localparam logic [2:0] P1 = 3'b010;
    localparam logic [2:0] P2 = 3'b100;

    logic       sysclk = 1'b0;
    logic       reset;
    logic       x0, x1, x2;
    logic [7:0] code_v;
    logic       unlocked, error, locked_out;
    logic [2:0] digit_count;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state.
    int q[$];
    int open_left, lock_left, fails;
    bit check_pending, exp_err;

    always #5 sysclk = ~sysclk;

    code_lock #(
        .CODE_LEN       (CL),
        .UNLOCK_CYCLES  (UC),
        .LOCKOUT_CYCLES (LC),
        .MAX_FAILS      (MF)
    ) dut (
        .sysclk      (sysclk),
        .reset       (reset),
        .X0_deb      (x0),
        .X1_deb      (x1),
        .X2_deb      (x2),
        .code        (code_v),
        .unlocked    (unlocked),
        .error       (error),
        .locked_out  (locked_out),
        .digit_count (digit_count)
    );

    function automatic int sym_of(input logic [2:0] x);
        case (x)
            3'b001:  return 0;
            3'b010:  return 1;
            3'b100:  return 2;
            default: return 3;
        endcase
    endfunction

    function automatic void model_reset();
        q.delete();
        open_left     = 0;
        lock_left     = 0;
        fails         = 0;
        check_pending = 1'b0;
        exp_err       = 1'b0;
    endfunction

    // One clock edge of the lock, with press vector x sampled at that edge.
    function automatic void model_step(input logic [2:0] x);
        bit all_ok;
        logic [1:0] want;
        exp_err = 1'b0;
        if (open_left > 0) begin
            open_left--;
        end else if (lock_left > 0) begin
            lock_left--;
            if (lock_left == 0) fails = 0;
        end else if (check_pending) begin
            all_ok = 1'b1;
            foreach (q[i]) begin
                want = code_v[2*i +: 2];
                if (q[i] == 3 || q[i] != int'(want)) all_ok = 1'b0;
            end
            q.delete();
            check_pending = 1'b0;
            if (all_ok) begin
                open_left = UC;
                fails     = 0;
            end else begin
                exp_err = 1'b1;
                fails++;
                if (LOCKOUT_EN && fails == MF) lock_left = LC;
            end
        end else if (x != 3'b000) begin
            q.push_back(sym_of(x));
            if (q.size() == CL) check_pending = 1'b1;
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string where);
        check({where, ".unlocked"},    32'(unlocked),    32'(open_left > 0));
        check({where, ".locked_out"},  32'(locked_out),  32'(lock_left > 0));
        check({where, ".error"},       32'(error),       32'(exp_err));
        check({where, ".digit_count"}, 32'(digit_count), 32'(q.size()));
    endtask

    task automatic tick(input logic [2:0] x);
        {x2, x1, x0} = x;
        @(posedge sysclk);
        model_step(x);
        #1;
        check_all("cycle");
    endtask

    task automatic idle(input int n);
        repeat (n) tick(3'b000);
    endtask

    // Random presses, including multi-button ones.
    task automatic rand_idle(input int n);
        repeat (n) tick(3'($urandom_range(0, 7)));
    endtask

    task automatic enter(input logic [2:0] a, input logic [2:0] b,
                         input logic [2:0] c, input logic [2:0] d);
        logic [2:0] s[4];
        s = '{a, b, c, d};
        for (int i = 0; i < 4; i++) begin
            tick(s[i]);
            if (i < 3) idle(int'($urandom_range(0, 2)));
        end
    endtask

    // After a final press: the CHECK cycle plus a full dwell of random presses.
    task automatic dwell(input int n);
        tick(3'b000);
        rand_idle(n);
    endtask

    // Asynchronous reset pulse applied mid-cycle.
    task automatic pulse_reset(input string where);
        {x2, x1, x0} = 3'b000;
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_all(where);
        @(posedge sysclk);
        #1;
        check_all(where);
        reset = 1'b1;
    endtask

    initial begin
        code_v = 8'b10_00_01_10;
        {x2, x1, x0} = 3'b000;
        reset = 1'b0;
        model_reset();
        #1;
        check_all("reset");
        @(posedge sysclk);
        #1;
        check_all("reset_edge");
        reset = 1'b1;

        // Correct entry, presses during OPEN ignored.
        enter(P2, P1, P0, P2);
        dwell(UC);
        idle(2);

        // Single wrong entry.
        enter(P2, P1, P1, P2);
        idle(3);

        // Three wrong in a row from a clean fail count, then lockout.
        pulse_reset("reset_clean");
        enter(P2, P1, P1, P2); idle(2);
        enter(P0, P0, P0, P0); idle(2);
        enter(P1, P1, P0, P2);
        dwell(LOCKOUT_EN ? LC : 0);
        enter(P2, P1, P0, P2);
        dwell(UC);
        idle(2);

        // Two wrong, correct, then three more wrong needed for lockout.
        enter(P2, P2, P0, P2); idle(1);
        enter(P2, P1, P0, P1); idle(1);
        enter(P2, P1, P0, P2);
        dwell(UC);
        enter(P0, P1, P0, P2); idle(1);
        enter(P2, P1, P2, P2); idle(1);
        enter(P2, P0, P0, P2);
        dwell(LOCKOUT_EN ? LC : 0);
        idle(2);

        // Simultaneous X0+X1 as the first symbol.
        enter(3'b011, P1, P0, P2);
        idle(3);

        // Reset mid-entry, then a normal unlock.
        tick(P2); tick(P1);
        pulse_reset("reset_mid_entry");
        enter(P2, P1, P0, P2);
        tick(3'b000);
        idle(3);
        pulse_reset("reset_open");
        enter(P2, P1, P0, P2);
        dwell(UC);
        idle(2);

        // Randomized entries; the model tracks any partial-entry carry-over.
        for (int e = 0; e < 40; e++) begin
            if ($urandom_range(0, 1) == 0) begin
                enter(P2, P1, P0, P2);
            end else begin
                enter(3'($urandom_range(1, 7)), 3'($urandom_range(1, 7)),
                      3'($urandom_range(1, 7)), 3'($urandom_range(1, 7)));
            end
            dwell(int'($urandom_range(0, 20)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
